// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit with a START/BUSY/DONE handshake.
// Shift-add multiply and restoring divide. Both take WIDTH iterations.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNTW  = 6
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [1:0]       FUNCT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [4:0]       DEST,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic [4:0]       WADDR,
    output logic             WEN
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [CNTW-1:0] LastCnt = CNTW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         funct_q, funct_d;
    logic [4:0]         dest_q, dest_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [4:0]         waddr_q, waddr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] iter_next;

    // Multiply: product accumulates in the upper half while the multiplier shifts out of b_q.
    // Divide: the dividend shifts out of a_q into the partial remainder in the upper half,
    // and quotient bits enter the lower half.
    always_comb begin
        mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
        mul_next  = {mul_sum, work_q[WIDTH-1:1]};
        rem_shift = {work_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
        div_diff  = {1'b0, rem_shift} - {2'b00, b_q};
        div_ok    = ~div_diff[WIDTH+1];
        div_next  = {(div_ok ? div_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                     work_q[WIDTH-2:0], div_ok};
        iter_next = funct_q[1] ? div_next : mul_next;
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        funct_d  = funct_q;
        dest_d   = dest_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        result_d = result_q;
        waddr_d  = waddr_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (START) begin
                    a_d     = DATA1;
                    b_d     = DATA2;
                    funct_d = FUNCT;
                    dest_d  = DEST;
                    cnt_d   = '0;
                    work_d  = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                work_d = iter_next;
                cnt_d  = cnt_q + CNTW'(1);
                if (funct_q[1]) begin
                    a_d = a_q << 1;
                end else begin
                    b_d = b_q >> 1;
                end
                if (cnt_q == LastCnt) begin
                    state_d  = StDone;
                    result_d = funct_q[0] ? iter_next[2*WIDTH-1:WIDTH] : iter_next[WIDTH-1:0];
                    waddr_d  = dest_q;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            funct_q  <= '0;
            dest_q   <= '0;
            cnt_q    <= '0;
            work_q   <= '0;
            result_q <= '0;
            waddr_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            funct_q  <= funct_d;
            dest_q   <= dest_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            result_q <= result_d;
            waddr_q  <= waddr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign WEN    = done_q;
    assign RESULT = result_q;
    assign WADDR  = waddr_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: fixed-latency results, handshake, operand capture
// and reset abort.
module tb_mul_div_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [1:0]  FUNCT;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic [4:0]  DEST;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;
    logic [4:0]  WADDR;
    logic        WEN;

    int passed = 0;
    int total  = 0;
    logic [31:0] last_result = 32'd0;
    logic [4:0]  last_waddr  = 5'd0;

    localparam logic [1:0] FMul = 2'b00, FMulhu = 2'b01, FDivu = 2'b10, FRemu = 2'b11;

    mul_div_unit #(.WIDTH(32), .CNTW(6)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .FUNCT  (FUNCT),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .DEST   (DEST),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT),
        .WADDR  (WADDR),
        .WEN    (WEN)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d);
        FUNCT = f;
        DATA1 = a;
        DATA2 = b;
        DEST  = d;
    endtask

    // Runs n RUN edges (must stay busy, no DONE, outputs held), then the final edge.
    task automatic finish_op(input int n, input logic [31:0] exp, input logic [4:0] d,
                             input string tag);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            DATA1 = $urandom;
            DATA2 = $urandom;
            DEST  = 5'($urandom);
            if (BUSY !== 1'b1 || DONE !== 1'b0 || WEN !== 1'b0 ||
                RESULT !== last_result || WADDR !== last_waddr) bad++;
        end
        check({tag, "_run_cycles_bad"}, 32'(bad), 32'd0);
        tick();
        check({tag, "_done"}, {30'd0, DONE, WEN}, 32'd3);
        check({tag, "_busy_low"}, {31'd0, BUSY}, 32'd0);
        check({tag, "_result"}, RESULT, exp);
        check({tag, "_waddr"}, {27'd0, WADDR}, {27'd0, d});
        last_result = exp;
        last_waddr  = d;
    endtask

    task automatic start_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] d, input string tag);
        drive(f, a, b, d);
        START = 1'b1;
        tick();
        START = 1'b0;
        check({tag, "_busy_after_accept"}, {31'd0, BUSY}, 32'd1);
    endtask

    task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, input logic [31:0] exp, input string tag);
        start_op(f, a, b, d, tag);
        finish_op(31, exp, d, tag);
        tick();
        check({tag, "_done_pulse_end"}, {30'd0, DONE, WEN}, 32'd0);
    endtask

    initial begin
        RESET = 1'b0;
        START = 1'b0;
        drive(FMul, 32'd0, 32'd0, 5'd0);
        tick();
        tick();
        check("reset_outputs", {BUSY, DONE, WEN, WADDR, 24'd0}, 32'd0);
        check("reset_result", RESULT, 32'd0);
        RESET = 1'b1;
        tick();

        run_op(FMul,   32'd7,         32'd6,         5'd5,  32'd42,        "mul_7x6");
        run_op(FMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,  32'hFFFF_FFFE, "mulhu_max");
        run_op(FMul,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'h0000_0001, "mul_max");
        run_op(FDivu,  32'd100,       32'd7,         5'd11, 32'd14,        "divu_100_7");
        run_op(FRemu,  32'd100,       32'd7,         5'd12, 32'd2,         "remu_100_7");
        run_op(FDivu,  32'h1234,      32'd0,         5'd13, 32'hFFFF_FFFF, "divu_by0");
        run_op(FRemu,  32'h1234,      32'd0,         5'd14, 32'h1234,      "remu_by0");
        run_op(FMulhu, 32'h8000_0000, 32'd6,         5'd15, 32'd3,         "mulhu_pow2");
        run_op(FDivu,  32'hFFFF_FFFF, 32'd1,         5'd16, 32'hFFFF_FFFF, "divu_by1");
        run_op(FRemu,  32'd5,         32'd9,         5'd17, 32'd5,         "remu_small");

        // START pulsed with new operands mid-run must be ignored.
        start_op(FMul, 32'd3, 32'd4, 5'd20, "mul_3x4");
        repeat (9) tick();
        drive(FDivu, 32'd999, 32'd3, 5'd7);
        START = 1'b1;
        tick();
        START = 1'b0;
        finish_op(21, 32'd12, 5'd20, "mul_3x4");

        // Back-to-back: START held through the DONE cycle.
        drive(FMul, 32'd11, 32'd13, 5'd21);
        START = 1'b1;
        tick();
        START = 1'b0;
        check("b2b_busy_again", {30'd0, BUSY, DONE}, 32'd2);
        finish_op(31, 32'd143, 5'd21, "b2b_mul");
        tick();

        // Reset during a divide aborts it without a write.
        start_op(FDivu, 32'd1000, 32'd10, 5'd22, "divu_abort");
        repeat (14) tick();
        RESET = 1'b0;
        tick();
        check("abort_outputs", {BUSY, DONE, WEN, WADDR, 24'd0}, 32'd0);
        check("abort_result", RESULT, 32'd0);
        last_result = 32'd0;
        last_waddr  = 5'd0;
        // Reset wins over a simultaneous START.
        START = 1'b1;
        tick();
        START = 1'b0;
        RESET = 1'b1;
        begin
            int wen_seen = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (WEN !== 1'b0 || BUSY !== 1'b0) wen_seen++;
            end
            check("abort_no_wen_or_busy", 32'(wen_seen), 32'd0);
        end

        run_op(FDivu, 32'd1000, 32'd10, 5'd23, 32'd100, "divu_after_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit unsigned multiply/divide unit for the single-cycle CPU datapath. It takes its operands from the register file read ports (OUT1 and OUT2) and returns its result to the register file write port (IN, INADDRESS and WRITE). It runs over multiple cycles and has a START/BUSY/DONE handshake, so the control unit can stall the pipeline while an operation is in flight.

## Interface
Parameters:
- WIDTH, 32, operand and result width.
- CNTW, 6, width of the iteration counter; must hold WIDTH.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-low reset; RESET==0 at a rising edge resets the block.
- START  input  1  request to begin an operation; sampled only in IDLE or DONE.
- FUNCT  input  2  operation select: 00 MUL (low product), 01 MULHU (high product), 10 DIVU, 11 REMU.
- DATA1  input  WIDTH  operand A; the multiplicand or dividend; driven by register file OUT1.
- DATA2  input  WIDTH  operand B; the multiplier or divisor; driven by register file OUT2.
- DEST  input  5  destination register address, captured together with the operands.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  one-cycle pulse marking a valid RESULT.
- RESULT  output  WIDTH  registered result; drives register file IN.
- WADDR  output  5  captured DEST; drives register file INADDRESS.
- WEN  output  1  equal to DONE; drives register file WRITE.

## Operation
- FSM states are IDLE, RUN and DONE. Reset places the FSM in IDLE.
- In IDLE, START=1 at a rising edge accepts an operation:
  - latches DATA1, DATA2, FUNCT and DEST;
  - clears the counter and the 64-bit work register;
  - moves to RUN.
- While in RUN, START is ignored and no second operation is queued.
- In RUN, each edge performs one iteration and increments the counter. When the counter reaches WIDTH, the FSM moves to DONE and the final value is loaded into RESULT.
- In DONE, DONE and WEN are high for exactly one cycle. The next edge goes to RUN if START=1 (back-to-back, with new operands latched), otherwise to IDLE.
- Multiply uses shift-add over 32 iterations with a 64-bit product.
  - MUL returns product[31:0].
  - MULHU returns product[63:32].
- Divide uses restoring division over 32 iterations, with a 33-bit partial remainder.
  - DIVU returns the quotient.
  - REMU returns the remainder.
- Divide by zero (DATA2==0) still takes the full 32 iterations.
  - DIVU returns 0xFFFFFFFF.
  - REMU returns DATA1.
- All arithmetic is unsigned, and no overflow flag is produced.
- RESULT and WADDR hold their values until the next completion. They do not change during RUN.

## Timing
- Reset values: BUSY=0, DONE=0, WEN=0, RESULT=0, WADDR=0. The counter and work register are 0 and the FSM is in IDLE.
- Let E0 be the accept edge. BUSY rises after E0 and falls after E32.
- DONE, WEN, RESULT and WADDR become valid after E32 and are valid for one cycle. Latency is 32 cycles from accept to DONE, independent of operand values.
- Operand and DEST changes after E0 do not affect the running operation.
- Reset asserted in the middle of an operation (RUN or DONE) aborts it at that edge. No WEN pulse is produced, and all outputs return to their reset values.
- If RESET==0 and START==1 arrive at the same edge, reset wins and nothing is accepted.
- The control unit must hold the PC and suppress other register writes while BUSY or DONE is high. The block itself performs no arbitration.

## Test plan
- MUL 7×6, DEST=5: START pulse → BUSY high for cycles 1–32; DONE=1, WEN=1, RESULT=42, WADDR=5 after E32; DONE=0 on the next cycle.
- MULHU and MUL of 0xFFFFFFFF × 0xFFFFFFFF: expect RESULT=0xFFFFFFFE for MULHU and 0x00000001 for MUL, each at exactly 32 cycles.
- DIVU and REMU of 100 ÷ 7: expect RESULT=14 and RESULT=2. With DATA2=0 and DATA1=0x1234, expect DIVU=0xFFFFFFFF and REMU=0x1234.
- START pulsed and operands changed at cycle 10 of a running MUL 3×4: no restart, and RESULT=12 at cycle 32. Holding START high through the DONE cycle starts a second operation immediately, with BUSY back high on the next cycle.
- RESET=0 at cycle 15 of a DIVU: no WEN pulse, all outputs 0, FSM in IDLE. A new START after reset is released completes normally in 32 cycles.
